// File: rtl/u_csatm8_mac.sv
// u_csatm8_mac: multiply-accumulate of truncated 8x8 unsigned products, LEN beats per frame.
// Ports: clk, rst_n (async low), clr (sync abort), in_valid/in_ready/in_a/in_b in, out_valid/out_ready/out_sum out.
module u_csatm8_mac #(
    parameter int LEN   = 8,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum
);

    localparam int CNT_W = $clog2(LEN);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        OUT     = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic             s1_valid;
    logic [15:0]      s1_prod;
    logic [ACC_W-1:0] acc;
    logic             first;

    logic [9:0]       prod_hi;
    logic [15:0]      prod;
    logic             accept;
    logic             last_beat;
    logic             out_fire;

    // Only the top five bits of each operand take part in the product.
    assign prod_hi = {5'b0, in_a[7:3]} * {5'b0, in_b[7:3]};
    assign prod    = {prod_hi, 6'b0};

    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == OUT);
    assign out_sum   = out_valid ? acc : '0;

    assign accept    = in_valid & in_ready & ~clr;
    assign last_beat = (cnt == CNT_W'(LEN - 1));
    assign out_fire  = out_valid & out_ready & ~clr;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            COLLECT: begin
                if (accept) begin
                    if (last_beat) begin
                        state_nxt = DRAIN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            DRAIN: begin
                state_nxt = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_nxt = COLLECT;
                end
            end
            default: begin
                state_nxt = COLLECT;
            end
        endcase
        if (clr) begin
            state_nxt = COLLECT;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Stage 1 holds the product of the beat accepted on the previous edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
        end else if (clr) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_prod <= prod;
            end
        end
    end

    // Stage 2: the first product of a frame overwrites the accumulator,
    // so nothing needs clearing after a completed frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            first <= 1'b1;
        end else if (clr) begin
            acc   <= '0;
            first <= 1'b1;
        end else begin
            if (s1_valid) begin
                acc   <= first ? ACC_W'(s1_prod) : acc + ACC_W'(s1_prod);
                first <= 1'b0;
            end
            if (out_fire) begin
                first <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_u_csatm8_mac.sv
// tb_u_csatm8_mac: directed frame table on LEN=4 plus random traffic on LEN 2/8/256.
// Ports: none; drives four DUT instances sharing clk and rst_n.
module tb_u_csatm8_mac;

    typedef struct packed {
        logic [3:0][7:0] a;
        logic [3:0][7:0] b;
        logic [7:0]      gap;
        logic [7:0]      hold;
        logic            rdy_early;
        logic [23:0]     sum;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr  [4];
    logic        iv   [4];
    logic        irdy [4];
    logic [7:0]  ia   [4];
    logic [7:0]  ib   [4];
    logic        ov   [4];
    logic        ordy [4];
    logic [23:0] os   [4];

    int total = 0;
    int bad = 0;
    int lens[4] = '{4, 2, 8, 256};

    always #5 clk = ~clk;

    u_csatm8_mac #(.LEN(4), .ACC_W(24)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr[0]),
        .in_valid(iv[0]), .in_ready(irdy[0]),
        .in_a(ia[0]), .in_b(ib[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(os[0])
    );
    u_csatm8_mac #(.LEN(2), .ACC_W(24)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr[1]),
        .in_valid(iv[1]), .in_ready(irdy[1]),
        .in_a(ia[1]), .in_b(ib[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(os[1])
    );
    u_csatm8_mac #(.LEN(8), .ACC_W(24)) u2 (
        .clk(clk), .rst_n(rst_n), .clr(clr[2]),
        .in_valid(iv[2]), .in_ready(irdy[2]),
        .in_a(ia[2]), .in_b(ib[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(os[2])
    );
    u_csatm8_mac #(.LEN(256), .ACC_W(24)) u3 (
        .clk(clk), .rst_n(rst_n), .clr(clr[3]),
        .in_valid(iv[3]), .in_ready(irdy[3]),
        .in_a(ia[3]), .in_b(ib[3]),
        .out_valid(ov[3]), .out_ready(ordy[3]), .out_sum(os[3])
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    function automatic int prd(input logic [7:0] a, input logic [7:0] b);
        return int'(a[7:3]) * int'(b[7:3]) * 64;
    endfunction

    function automatic vec_t mk(
        input logic [7:0] a0, b0, a1, b1, a2, b2, a3, b3,
        input logic [7:0] gap, hold, input logic early,
        input logic [23:0] sum);
        vec_t v;
        v.a = {a3, a2, a1, a0};
        v.b = {b3, b2, b1, b0};
        v.gap = gap;
        v.hold = hold;
        v.rdy_early = early;
        v.sum = sum;
        return v;
    endfunction

    task automatic beat(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        iv[0] = 1'b1;
        ia[0] = a;
        ib[0] = b;
        @(negedge clk);
        iv[0] = 1'b0;
    endtask

    task automatic run_frame(input vec_t v, input bit hs);
        ordy[0] = v.rdy_early;
        for (int k = 0; k < 4; k++) begin
            beat(v.a[k], v.b[k]);
            if (k == 0) begin
                chk("mid_sum_zero", os[0], 0);
                chk("mid_ready", irdy[0], 1);
            end
            if (k < 3) repeat (int'(v.gap)) @(negedge clk);
        end
        ordy[0] = 1'b0;
        chk("lat_e1_valid", ov[0], 0);
        chk("drain_ready", irdy[0], 0);
        @(negedge clk);
        chk("lat_e2_valid", ov[0], 1);
        chk("frame_sum", os[0], v.sum);
        for (int h = 0; h < int'(v.hold); h++) begin
            @(negedge clk);
            chk("hold_valid", ov[0], 1);
            chk("hold_sum", os[0], v.sum);
            chk("hold_ready", irdy[0], 0);
        end
        if (hs) begin
            ordy[0] = 1'b1;
            @(negedge clk);
            ordy[0] = 1'b0;
            chk("hs_ready", irdy[0], 1);
            chk("hs_valid", ov[0], 0);
            chk("hs_sum_zero", os[0], 0);
        end
    endtask

    vec_t vt[8];
    int   exp_sum[4];
    logic pend[4];
    int   msum[4];
    int   mcnt[4];
    int   nres[4];

    initial begin
        for (int i = 0; i < 4; i++) begin
            clr[i] = 1'b0;
            iv[i] = 1'b0;
            ia[i] = '0;
            ib[i] = '0;
            ordy[i] = 1'b0;
        end

        vt[0] = mk(255, 255, 255, 255, 255, 255, 255, 255, 0, 5, 0, 24'd246016);
        vt[1] = mk(7, 255, 8, 8, 8, 8, 255, 7, 3, 0, 0, 24'd128);
        vt[2] = mk(200, 100, 128, 64, 255, 255, 0, 255, 1, 0, 1, 24'd88896);
        vt[3] = mk(8, 255, 255, 8, 9, 15, 63, 63, 2, 0, 0, 24'd7168);
        vt[4] = mk(7, 7, 7, 7, 7, 7, 7, 7, 0, 0, 0, 24'd0);
        vt[5] = mk(248, 8, 8, 248, 31, 31, 128, 128, 0, 1, 0, 24'd20928);
        vt[6] = mk(16, 16, 16, 16, 16, 16, 16, 16, 0, 0, 0, 24'd1024);
        vt[7] = mk(8, 8, 8, 8, 8, 8, 8, 8, 0, 0, 0, 24'd256);

        rst_n = 1'b0;
        #1;
        chk("rst_ready", irdy[0], 1);
        chk("rst_valid", ov[0], 0);
        chk("rst_sum", os[0], 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 6; n++) begin
            run_frame(vt[n], 1'b1);
        end

        // Abort with clr coincident with a third offered beat.
        beat(255, 255);
        beat(255, 255);
        @(negedge clk);
        iv[0] = 1'b1;
        ia[0] = 255;
        ib[0] = 255;
        clr[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        clr[0] = 1'b0;
        chk("clr_ready", irdy[0], 1);
        chk("clr_sum", os[0], 0);
        run_frame(vt[6], 1'b1);

        // Reset pulse while a result is waiting.
        run_frame(vt[0], 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", ov[0], 0);
        chk("rst_out_ready", irdy[0], 1);
        chk("rst_out_sum", os[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(vt[7], 1'b1);

        // Random traffic on all instances against a per-beat model.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pend[i] = 1'b0;
            exp_sum[i] = 0;
            msum[i] = 0;
            mcnt[i] = 0;
            nres[i] = 0;
        end
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                iv[i] = ($urandom_range(0, 3) != 0);
                ia[i] = 8'($urandom_range(0, 255));
                ib[i] = 8'($urandom_range(0, 255));
                ordy[i] = 1'($urandom_range(0, 1));
                if (ov[i] && ordy[i]) begin
                    if (!pend[i]) begin
                        chk("rnd_unexpected", 1, 0);
                    end else begin
                        chk("rnd_sum", os[i], exp_sum[i]);
                    end
                    pend[i] = 1'b0;
                    nres[i]++;
                end
                if (iv[i] && irdy[i]) begin
                    msum[i] += prd(ia[i], ib[i]);
                    mcnt[i]++;
                    if (mcnt[i] == lens[i]) begin
                        exp_sum[i] = msum[i];
                        pend[i] = 1'b1;
                        msum[i] = 0;
                        mcnt[i] = 0;
                    end
                end
            end
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            iv[i] = 1'b0;
            ordy[i] = 1'b0;
            chk("rnd_results_seen", 32'(nres[i] > 0), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
